zilla_lsu_req: RTL and testbench

ZILLA_LSU_REQ -- requirements
Module: zilla_lsu_req

---
 rtl/zilla_lsu_req.sv | 184 ++++++++++++++++++
 tb/tb_zilla_lsu_req.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/zilla_lsu_req.sv
// zilla_lsu_req: load/store request issue stage.
//
// Takes one execute-stage memory request at a time. It forms the effective
// address (base + offset), screens the request for illegal encodings and
// misalignment, and then drives one write or read transaction on the memory
// interface.
//
// Ports:
//   mem_clk, mem_rst      clock (rising edge); asynchronous active-low reset
//   req_valid_i/ready_o   request handshake; ready only in idle
//   is_load_i, is_store_i request type
//   funct3_i              access size / signedness code
//   base_i, offset_i      address operands
//   store_data_i          LSB-justified store operand
//   stall_i               holds an issued transaction on the memory interface
//   wr_en_o, wr_addr_o, wr_data_o   memory write channel
//   rd_en_o, rd_addr_o              memory read channel
//   byte_en_o, sign_bit_o           lane enables and signed-load flag
//   load_done_o           load data valid at the memory-interface output
//   misalign_o, bad_addr_o          misaligned-access pulse and faulting address
//   illegal_o             illegal-request pulse
module zilla_lsu_req #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  mem_clk,
    input  logic                  mem_rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  is_load_i,
    input  logic                  is_store_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] base_i,
    input  logic [DATA_WIDTH-1:0] offset_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    input  logic                  stall_i,
    output logic                  wr_en_o,
    output logic                  rd_en_o,
    output logic [DATA_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] rd_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic [3:0]            byte_en_o,
    output logic                  sign_bit_o,
    output logic                  load_done_o,
    output logic                  misalign_o,
    output logic [DATA_WIDTH-1:0] bad_addr_o,
    output logic                  illegal_o
);

    typedef enum logic [1:0] {
        StIdle,
        StStIssue,
        StLdIssue,
        StLdResp
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            be_q, be_d;
    logic                  sign_q, sign_d;
    logic [DATA_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] bad_addr_q, bad_addr_d;
    logic                  misalign_q, misalign_d;
    logic                  illegal_q, illegal_d;

    logic [DATA_WIDTH-1:0] ea;
    logic                  accept;
    logic                  ld_f3_ok, st_f3_ok;
    logic                  req_illegal, req_misal;
    logic [3:0]            size_mask;

    assign ea     = base_i + offset_i;
    assign accept = req_valid_i && req_ready_o;

    always_comb begin
        ld_f3_ok = 1'b0;
        st_f3_ok = 1'b0;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: begin
                ld_f3_ok = 1'b1;
                st_f3_ok = 1'b1;
            end
            3'b100, 3'b101: ld_f3_ok = 1'b1;
            default: ;
        endcase
    end

    assign req_illegal = (is_load_i && is_store_i)
                       || (is_load_i && !ld_f3_ok)
                       || (is_store_i && !st_f3_ok);

    // funct3[1:0] encodes size: 00 byte, 01 half, 10 word.
    assign req_misal = ((funct3_i[1:0] == 2'b01) && ea[0])
                     || ((funct3_i[1:0] == 2'b10) && (ea[1:0] != 2'b00));

    always_comb begin
        case (funct3_i[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        be_d       = be_q;
        sign_d     = sign_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wr_data_d  = wr_data_q;
        bad_addr_d = bad_addr_q;
        misalign_d = 1'b0;
        illegal_d  = 1'b0;

        case (state_q)
            StIdle: begin
                // A valid request flagged as neither load nor store is dropped.
                if (accept) begin
                    if (req_illegal) begin
                        illegal_d = 1'b1;
                    end else if ((is_load_i || is_store_i) && req_misal) begin
                        misalign_d = 1'b1;
                        bad_addr_d = ea;
                    end else if (is_store_i) begin
                        state_d   = StStIssue;
                        wr_addr_d = ea;
                        wr_data_d = store_data_i << {ea[1:0], 3'b000};
                        be_d      = size_mask << ea[1:0];
                        sign_d    = 1'b0;
                    end else if (is_load_i) begin
                        state_d   = StLdIssue;
                        rd_addr_d = ea;
                        // Load lanes are unshifted; downstream selects from the address.
                        be_d      = size_mask;
                        sign_d    = ~funct3_i[2];
                    end
                end
            end
            StStIssue: if (!stall_i) state_d = StIdle;
            StLdIssue: if (!stall_i) state_d = StLdResp;
            StLdResp:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge mem_clk or negedge mem_rst) begin
        if (!mem_rst) begin
            state_q    <= StIdle;
            be_q       <= '0;
            sign_q     <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_data_q  <= '0;
            bad_addr_q <= '0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            be_q       <= be_d;
            sign_q     <= sign_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wr_data_q  <= wr_data_d;
            bad_addr_q <= bad_addr_d;
            misalign_q <= misalign_d;
            illegal_q  <= illegal_d;
        end
    end

    // Ready is gated by reset so it reads 0 while reset is held.
    assign req_ready_o = (state_q == StIdle) && mem_rst;
    assign wr_en_o     = (state_q == StStIssue);
    assign rd_en_o     = (state_q == StLdIssue);
    assign load_done_o = (state_q == StLdResp);
    assign byte_en_o   = (state_q == StIdle) ? 4'b0000 : be_q;
    assign sign_bit_o  = (state_q == StIdle) ? 1'b0 : sign_q;
    assign wr_addr_o   = wr_addr_q;
    assign rd_addr_o   = rd_addr_q;
    assign wr_data_o   = wr_data_q;
    assign bad_addr_o  = bad_addr_q;
    assign misalign_o  = misalign_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_zilla_lsu_req.sv
module tb_zilla_lsu_req;

    logic        mem_clk;
    logic        mem_rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        is_load_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] base_i;
    logic [31:0] offset_i;
    logic [31:0] store_data_i;
    logic        stall_i;
    logic        wr_en_o;
    logic        rd_en_o;
    logic [31:0] wr_addr_o;
    logic [31:0] rd_addr_o;
    logic [31:0] wr_data_o;
    logic [3:0]  byte_en_o;
    logic        sign_bit_o;
    logic        load_done_o;
    logic        misalign_o;
    logic [31:0] bad_addr_o;
    logic        illegal_o;

    int n_chk  = 0;
    int n_pass = 0;

    zilla_lsu_req #(.DATA_WIDTH(32)) dut (
        .mem_clk      (mem_clk),
        .mem_rst      (mem_rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .is_load_i    (is_load_i),
        .is_store_i   (is_store_i),
        .funct3_i     (funct3_i),
        .base_i       (base_i),
        .offset_i     (offset_i),
        .store_data_i (store_data_i),
        .stall_i      (stall_i),
        .wr_en_o      (wr_en_o),
        .rd_en_o      (rd_en_o),
        .wr_addr_o    (wr_addr_o),
        .rd_addr_o    (rd_addr_o),
        .wr_data_o    (wr_data_o),
        .byte_en_o    (byte_en_o),
        .sign_bit_o   (sign_bit_o),
        .load_done_o  (load_done_o),
        .misalign_o   (misalign_o),
        .bad_addr_o   (bad_addr_o),
        .illegal_o    (illegal_o)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one cycle and sample just after the rising edge.
    task automatic step();
        @(posedge mem_clk);
        #1;
    endtask

    // Present a request for one accepting edge, then withdraw it.
    task automatic req(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] b, input logic [31:0] o, input logic [31:0] d);
        req_valid_i  = 1'b1;
        is_load_i    = ld;
        is_store_i   = st;
        funct3_i     = f3;
        base_i       = b;
        offset_i     = o;
        store_data_i = d;
        step();
        req_valid_i  = 1'b0;
        // Scramble operands so any late sampling shows up.
        base_i       = 32'hDEAD_0000;
        store_data_i = 32'h5555_5555;
    endtask

    initial begin
        mem_rst = 1'b0;
        req_valid_i = 1'b0;
        is_load_i = 1'b0;
        is_store_i = 1'b0;
        funct3_i = 3'b000;
        base_i = '0;
        offset_i = '0;
        store_data_i = '0;
        stall_i = 1'b0;

        #3;
        check("rst_ready", {31'b0, req_ready_o}, 32'd0);
        check("rst_enables", {29'b0, wr_en_o, rd_en_o, load_done_o}, 32'd0);
        check("rst_wr_addr", wr_addr_o, 32'd0);
        check("rst_be", {28'b0, byte_en_o}, 32'd0);
        #9 mem_rst = 1'b1;
        step();
        check("ready_after_rst", {31'b0, req_ready_o}, 32'd1);

        // SB to 0x103: lane 3.
        req(1'b0, 1'b1, 3'b000, 32'h100, 32'd3, 32'h0000_00AB);
        check("sb_wr_en", {31'b0, wr_en_o}, 32'd1);
        check("sb_wr_addr", wr_addr_o, 32'h103);
        check("sb_be", {28'b0, byte_en_o}, 32'b1000);
        check("sb_wr_data", wr_data_o, 32'hAB00_0000);
        check("sb_ready", {31'b0, req_ready_o}, 32'd0);
        step();
        check("sb_wr_en_off", {31'b0, wr_en_o}, 32'd0);
        check("sb_idle_ready", {31'b0, req_ready_o}, 32'd1);
        check("sb_idle_be", {28'b0, byte_en_o}, 32'd0);
        check("sb_addr_hold", wr_addr_o, 32'h103);

        // LH from 0x202.
        req(1'b1, 1'b0, 3'b001, 32'h200, 32'd2, 32'd0);
        check("lh_rd_en", {31'b0, rd_en_o}, 32'd1);
        check("lh_rd_addr", rd_addr_o, 32'h202);
        check("lh_be", {28'b0, byte_en_o}, 32'b0011);
        check("lh_sign", {31'b0, sign_bit_o}, 32'd1);
        check("lh_ready0", {31'b0, req_ready_o}, 32'd0);
        step();
        check("lh_resp_rd_en", {31'b0, rd_en_o}, 32'd0);
        check("lh_done", {31'b0, load_done_o}, 32'd1);
        check("lh_resp_be", {28'b0, byte_en_o}, 32'b0011);
        check("lh_resp_sign", {31'b0, sign_bit_o}, 32'd1);
        check("lh_ready1", {31'b0, req_ready_o}, 32'd0);
        step();
        check("lh_done_off", {31'b0, load_done_o}, 32'd0);
        check("lh_idle_ready", {31'b0, req_ready_o}, 32'd1);
        check("lh_idle_sign", {31'b0, sign_bit_o}, 32'd0);

        // LW at 0x1001: misaligned.
        req(1'b1, 1'b0, 3'b010, 32'h1000, 32'd1, 32'd0);
        check("lw_mis_pulse", {31'b0, misalign_o}, 32'd1);
        check("lw_mis_addr", bad_addr_o, 32'h1001);
        check("lw_mis_rd_en", {31'b0, rd_en_o}, 32'd0);
        check("lw_mis_ready", {31'b0, req_ready_o}, 32'd1);
        step();
        check("lw_mis_clear", {31'b0, misalign_o}, 32'd0);
        check("lw_mis_addr_hold", bad_addr_o, 32'h1001);
        check("lw_mis_rd_en2", {31'b0, rd_en_o}, 32'd0);

        // SW to 0x40 held by a 3-cycle stall.
        req(1'b0, 1'b1, 3'b010, 32'h40, 32'd0, 32'h1234_5678);
        check("sw_wr_en", {31'b0, wr_en_o}, 32'd1);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("sw_stall_wr_en", {31'b0, wr_en_o}, 32'd1);
            check("sw_stall_addr", wr_addr_o, 32'h40);
            check("sw_stall_data", wr_data_o, 32'h1234_5678);
            check("sw_stall_be", {28'b0, byte_en_o}, 32'b1111);
        end
        stall_i = 1'b0;
        step();
        check("sw_wr_en_off", {31'b0, wr_en_o}, 32'd0);
        check("sw_ready", {31'b0, req_ready_o}, 32'd1);

        // SH to 0x302: upper half lanes.
        req(1'b0, 1'b1, 3'b001, 32'h300, 32'd2, 32'h0000_BEEF);
        check("sh_be", {28'b0, byte_en_o}, 32'b1100);
        check("sh_data", wr_data_o, 32'hBEEF_0000);
        step();

        // Illegal: funct3 011 load, then load+store together.
        req(1'b1, 1'b0, 3'b011, 32'h0, 32'd0, 32'd0);
        check("ill_f3_pulse", {31'b0, illegal_o}, 32'd1);
        check("ill_f3_en", {30'b0, wr_en_o, rd_en_o}, 32'd0);
        check("ill_f3_ready", {31'b0, req_ready_o}, 32'd1);
        step();
        check("ill_f3_clear", {31'b0, illegal_o}, 32'd0);
        req(1'b1, 1'b1, 3'b000, 32'h0, 32'd0, 32'd0);
        check("ill_both_pulse", {31'b0, illegal_o}, 32'd1);
        check("ill_both_en", {30'b0, wr_en_o, rd_en_o}, 32'd0);
        step();

        // Reset asserted during LD_ISSUE aborts the load.
        req(1'b1, 1'b0, 3'b010, 32'h500, 32'd0, 32'd0);
        check("abort_rd_en", {31'b0, rd_en_o}, 32'd1);
        #1 mem_rst = 1'b0;
        #1;
        check("abort_rd_en_off", {31'b0, rd_en_o}, 32'd0);
        check("abort_rd_addr", rd_addr_o, 32'd0);
        check("abort_be", {28'b0, byte_en_o}, 32'd0);
        check("abort_ready", {31'b0, req_ready_o}, 32'd0);
        #1 mem_rst = 1'b1;
        step();
        check("abort_no_done", {31'b0, load_done_o}, 32'd0);
        check("abort_ready2", {31'b0, req_ready_o}, 32'd1);
        step();
        check("abort_no_done2", {30'b0, load_done_o, rd_en_o}, 32'd0);

        // LBU with address wrap.
        req(1'b1, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'd0);
        check("lbu_rd_addr", rd_addr_o, 32'd0);
        check("lbu_rd_en", {31'b0, rd_en_o}, 32'd1);
        check("lbu_sign", {31'b0, sign_bit_o}, 32'd0);
        check("lbu_be", {28'b0, byte_en_o}, 32'b0001);
        step();
        check("lbu_done", {31'b0, load_done_o}, 32'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
